// File: rtl/act_buf_write_arbiter.sv
// act_buf_write_arbiter
//   Round-robin write scheduler for the single-port activation buffer SRAM.
//   NUM_REQ write requesters compete for a one-entry output register, which
//   shares the SRAM port with the read path. Reads win by default. A write
//   that has lost MAX_STALL consecutive cycles to reads is forced through for
//   one cycle.
//
// Ports
//   clk        clock, all state on posedge
//   rst        asynchronous reset, active-high
//   req_valid  per-requester write valid
//   req_data   packed [NUM_REQ-1:0][DATA_W-1:0] write data
//   req_addr   packed [NUM_REQ-1:0][ADDR_W-1:0] write address
//   req_ready  one-hot (or zero) grant; a transfer is valid & ready
//   rd_req     read path requests the SRAM port this cycle
//   rd_gnt     read path owns the SRAM port this cycle
//   mem_we     SRAM write strobe
//   mem_addr   SRAM write address (meaningful when mem_we)
//   mem_wdata  SRAM write data (meaningful when mem_we)
//   busy       output register holds a write or any req_valid is high
module act_buf_write_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int MAX_STALL = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        rd_req,
    output logic                        rd_gnt,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(MAX_STALL);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

    logic              wr_v;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [PTR_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  stall_cnt;

    logic              force_wr;
    logic              can_load;
    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  grant_next_ptr;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    assign force_wr  = wr_v && (stall_cnt == STALL_MAX);
    // rst gating keeps the read grant low while reset is held, independent of
    // whatever the counter happened to contain before the async clear.
    assign rd_gnt    = rd_req && !force_wr && !rst;
    assign mem_we    = wr_v && !rd_gnt;
    assign mem_addr  = wr_addr;
    assign mem_wdata = wr_data;
    // The register can take a new write when empty or when it drains this cycle.
    assign can_load  = !wr_v || mem_we;
    assign busy      = !rst && (wr_v || (|req_valid));

    // Round-robin search starting at rr_ptr and wrapping at NUM_REQ-1.
    always_comb begin
        int               idx_full;
        logic [PTR_W-1:0] idx;
        idx_full    = 0;
        idx         = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        req_ready   = '0;
        if (can_load && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx_full = int'(rr_ptr) + k;
                if (idx_full >= NUM_REQ) begin
                    idx_full = idx_full - NUM_REQ;
                end
                idx = PTR_W'(idx_full);
                if (!grant_found && req_valid[idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = idx;
                end
            end
            if (grant_found) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_addr     = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        grant_data     = req_data[int'(grant_idx)*DATA_W +: DATA_W];
        grant_next_ptr = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_v      <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
        end else begin
            if (grant_found) begin
                wr_v    <= 1'b1;
                wr_addr <= grant_addr;
                wr_data <= grant_data;
                rr_ptr  <= grant_next_ptr;
            end else if (mem_we) begin
                wr_v <= 1'b0;
            end

            // Counts consecutive cycles the held write lost to a read.
            if (mem_we || !wr_v) begin
                stall_cnt <= '0;
            end else if (rd_gnt && (stall_cnt != STALL_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_act_buf_write_arbiter.sv
module tb_act_buf_write_arbiter;

    localparam int NA  = 8;
    localparam int NB  = 5;
    localparam int MXA = 15;
    localparam int MXB = 3;
    localparam int DW  = 32;
    localparam int AW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NA-1:0]    va = '0;
    logic [NA*DW-1:0] da = '0;
    logic [NA*AW-1:0] aa = '0;
    logic             rda = 1'b0;
    logic [NA-1:0]    ra;
    logic             rga, wea, busya;
    logic [AW-1:0]    addra;
    logic [DW-1:0]    wdata_a;

    logic [NB-1:0]    vb = '0;
    logic [NB*DW-1:0] db = '0;
    logic [NB*AW-1:0] ab = '0;
    logic             rdb = 1'b0;
    logic [NB-1:0]    rb;
    logic             rgb, web, busyb;
    logic [AW-1:0]    addrb;
    logic [DW-1:0]    wdata_b;

    act_buf_write_arbiter #(.NUM_REQ(NA), .DATA_W(DW), .ADDR_W(AW), .MAX_STALL(MXA)) dut_a (
        .clk(clk), .rst(rst), .req_valid(va), .req_data(da), .req_addr(aa),
        .req_ready(ra), .rd_req(rda), .rd_gnt(rga), .mem_we(wea),
        .mem_addr(addra), .mem_wdata(wdata_a), .busy(busya)
    );

    act_buf_write_arbiter #(.NUM_REQ(NB), .DATA_W(DW), .ADDR_W(AW), .MAX_STALL(MXB)) dut_b (
        .clk(clk), .rst(rst), .req_valid(vb), .req_data(db), .req_addr(ab),
        .req_ready(rb), .rd_req(rdb), .rd_gnt(rgb), .mem_we(web),
        .mem_addr(addrb), .mem_wdata(wdata_b), .busy(busyb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: the held write, how many reads it has lost in a row,
    // and the requester index that has priority next.
    bit            m_pend[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_data[2];
    int            m_lost[2];
    int            m_ptr[2];

    task automatic model_eval(input int inst);
        int            n, mx, g;
        bit            v[NA];
        logic [AW-1:0] a[NA];
        logic [DW-1:0] d[NA];
        bit            rq, forced, e_rd, e_we, room, anyv;
        logic [NA-1:0] e_ready, act_ready;
        logic          act_rg, act_we, act_busy;
        logic [AW-1:0] act_addr;
        logic [DW-1:0] act_data;
        string         p;
        n  = (inst == 0) ? NA : NB;
        mx = (inst == 0) ? MXA : MXB;
        p  = (inst == 0) ? "a" : "b";
        for (int i = 0; i < NA; i++) begin
            v[i] = 1'b0; a[i] = '0; d[i] = '0;
        end
        if (inst == 0) begin
            for (int i = 0; i < NA; i++) begin
                v[i] = va[i]; a[i] = aa[i*AW +: AW]; d[i] = da[i*DW +: DW];
            end
            rq = rda; act_ready = ra; act_rg = rga; act_we = wea;
            act_busy = busya; act_addr = addra; act_data = wdata_a;
        end else begin
            for (int i = 0; i < NB; i++) begin
                v[i] = vb[i]; a[i] = ab[i*AW +: AW]; d[i] = db[i*DW +: DW];
            end
            rq = rdb; act_ready = {{(NA-NB){1'b0}}, rb}; act_rg = rgb; act_we = web;
            act_busy = busyb; act_addr = addrb; act_data = wdata_b;
        end

        if (rst) begin
            m_pend[inst] = 1'b0; m_lost[inst] = 0; m_ptr[inst] = 0;
            m_addr[inst] = '0;   m_data[inst] = '0;
            chk({p, ".rst_ready"}, act_ready, 0);
            chk({p, ".rst_rd_gnt"}, act_rg, 0);
            chk({p, ".rst_mem_we"}, act_we, 0);
            chk({p, ".rst_mem_addr"}, act_addr, 0);
            chk({p, ".rst_mem_wdata"}, act_data, 0);
            chk({p, ".rst_busy"}, act_busy, 0);
        end else begin
            forced = m_pend[inst] && (m_lost[inst] >= mx);
            e_rd   = rq && !forced;
            e_we   = m_pend[inst] && !e_rd;
            room   = !m_pend[inst] || e_we;
            g      = -1;
            if (room) begin
                for (int k = 0; k < n; k++) begin
                    int i;
                    i = (m_ptr[inst] + k) % n;
                    if (g < 0 && v[i]) g = i;
                end
            end
            e_ready = '0;
            if (g >= 0) e_ready = NA'(1) << g;
            anyv = 1'b0;
            for (int i = 0; i < n; i++) anyv = anyv | v[i];

            chk({p, ".req_ready"}, act_ready, e_ready);
            chk({p, ".rd_gnt"}, act_rg, e_rd);
            chk({p, ".mem_we"}, act_we, e_we);
            chk({p, ".busy"}, act_busy, m_pend[inst] || anyv);
            if (e_we) begin
                chk({p, ".mem_addr"}, act_addr, m_addr[inst]);
                chk({p, ".mem_wdata"}, act_data, m_data[inst]);
            end

            if (e_we || !m_pend[inst]) m_lost[inst] = 0;
            else if (e_rd && m_lost[inst] < mx) m_lost[inst] = m_lost[inst] + 1;
            if (g >= 0) begin
                m_pend[inst] = 1'b1;
                m_addr[inst] = a[g];
                m_data[inst] = d[g];
                m_ptr[inst]  = (g + 1) % n;
            end else if (e_we) begin
                m_pend[inst] = 1'b0;
            end
        end
    endtask

    // Scoreboards of accepted writes (taken from the handshake) and their grant cycle.
    logic [AW+DW-1:0] sqa[$];
    int               tqa[$];
    logic [AW+DW-1:0] sqb[$];
    int               tqb[$];
    int               wait_b[NB];
    bit               xfer_b[NB];

    always @(negedge clk) begin
        logic [AW+DW-1:0] ent;
        int               t;
        cyc++;
        model_eval(0);
        model_eval(1);
        if (rst) begin
            sqa.delete(); tqa.delete(); sqb.delete(); tqb.delete();
            for (int i = 0; i < NB; i++) begin
                wait_b[i] = 0; xfer_b[i] = 1'b0;
            end
        end else begin
            if (wea) begin
                if (sqa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a.sb_extra_write at cycle %0d: got mem_we=1 with nothing outstanding, expected 0", cyc);
                end else begin
                    ent = sqa.pop_front(); t = tqa.pop_front();
                    chk("a.sb_addr", addra, ent[AW+DW-1:DW]);
                    chk("a.sb_data", wdata_a, ent[DW-1:0]);
                    checks++;
                    if (cyc - t > MXA + 1) begin
                        errors++;
                        $display("FAIL a.write_latency at cycle %0d: got %0d cycles, expected <= %0d", cyc, cyc - t, MXA + 1);
                    end
                end
            end
            for (int i = 0; i < NA; i++) begin
                if (va[i] && ra[i]) begin
                    sqa.push_back({aa[i*AW +: AW], da[i*DW +: DW]});
                    tqa.push_back(cyc);
                end
            end

            if (web) begin
                if (sqb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b.sb_extra_write at cycle %0d: got mem_we=1 with nothing outstanding, expected 0", cyc);
                end else begin
                    ent = sqb.pop_front(); t = tqb.pop_front();
                    chk("b.sb_addr", addrb, ent[AW+DW-1:DW]);
                    chk("b.sb_data", wdata_b, ent[DW-1:0]);
                    checks++;
                    if (cyc - t > MXB + 1) begin
                        errors++;
                        $display("FAIL b.write_latency at cycle %0d: got %0d cycles, expected <= %0d", cyc, cyc - t, MXB + 1);
                    end
                end
            end
            for (int i = 0; i < NB; i++) begin
                xfer_b[i] = 1'b0;
                if (vb[i]) begin
                    if (rb[i]) begin
                        sqb.push_back({ab[i*AW +: AW], db[i*DW +: DW]});
                        tqb.push_back(cyc);
                        checks++;
                        if (wait_b[i] > NB - 1) begin
                            errors++;
                            $display("FAIL b.fairness req %0d at cycle %0d: got %0d other grants, expected <= %0d", i, cyc, wait_b[i], NB - 1);
                        end
                        wait_b[i] = 0;
                        xfer_b[i] = 1'b1;
                    end else if (rb != '0) begin
                        wait_b[i] = wait_b[i] + 1;
                    end
                end else begin
                    wait_b[i] = 0;
                end
            end
        end
    end

    task automatic mid;
        @(negedge clk); #1;
    endtask

    task automatic nxt;
        @(posedge clk); #1;
    endtask

    initial begin
        int rd_cnt;
        repeat (2) @(posedge clk);
        mid;
        chk("t1.rst_ready", ra, 0);
        chk("t1.rst_mem_we", wea, 0);
        chk("t1.rst_busy", busya, 0);
        nxt;

        // All requesters valid, no reads: strict rotation, writes one cycle late.
        rst = 1'b0;
        for (int i = 0; i < NA; i++) begin
            aa[i*AW +: AW] = AW'(16'h0100 + i);
            da[i*DW +: DW] = DW'(32'hD000_0000 + i);
        end
        va = '1;
        for (int c = 0; c < 9; c++) begin
            mid;
            chk("t1.ready", ra, NA'(1) << (c % 8));
            if (c == 0) begin
                chk("t1.first_we", wea, 0);
            end else begin
                chk("t1.we", wea, 1);
                chk("t1.addr", addra, 16'h0100 + ((c - 1) % 8));
            end
            nxt;
        end

        // Pointer parked at 3 with requesters 2 and 7 valid.
        va = '0; nxt;
        va = 8'h04; mid; chk("t2.setup", ra, 8'h04); nxt;
        va = 8'h84; mid; chk("t2.hi", ra, 8'h80); nxt;
        mid; chk("t2.wrap", ra, 8'h04); nxt;
        va = '0; nxt; nxt;

        // One pending write against a continuous read request.
        va = 8'h01; mid; chk("t3.grant", ra, 8'h01); nxt;
        va = '0; rda = 1'b1;
        rd_cnt = 0;
        for (int k = 0; k < 17; k++) begin
            mid;
            if (rga) rd_cnt++;
            chk("t3.rd_gnt", rga, (k != 15));
            chk("t3.mem_we", wea, (k == 15));
            nxt;
        end
        chk("t3.rd_won_cycles", rd_cnt, 16);
        rda = 1'b0;

        // Single continuous requester with alternating reads.
        va = 8'h01;
        for (int k = 0; k < 200; k++) begin
            aa[0 +: AW] = AW'($urandom);
            da[0 +: DW] = $urandom;
            rda = ~rda;
            nxt;
        end

        // Reset while a write is held and a read is requested.
        va = 8'h01; rda = 1'b1;
        repeat (3) nxt;
        rst = 1'b1; va = 8'h60;
        mid;
        chk("t5.ready", ra, 0);
        chk("t5.rd_gnt", rga, 0);
        chk("t5.mem_we", wea, 0);
        nxt;
        rst = 1'b0;
        mid;
        chk("t5.no_we_after", wea, 0);
        chk("t5.lowest", ra, 8'h20);
        chk("t5.rd_gnt_after", rga, 1);
        nxt;

        // Random traffic on both instances; instance b holds valid until accepted.
        for (int c = 0; c < 10000; c++) begin
            va = NA'($urandom);
            for (int i = 0; i < NA; i++) begin
                aa[i*AW +: AW] = AW'($urandom);
                da[i*DW +: DW] = $urandom;
            end
            rda = 1'($urandom_range(0, 1));
            for (int i = 0; i < NB; i++) begin
                if (xfer_b[i] || !vb[i]) begin
                    vb[i] = ($urandom_range(0, 9) < 4);
                    ab[i*AW +: AW] = AW'($urandom);
                    db[i*DW +: DW] = $urandom;
                end
            end
            rdb = ($urandom_range(0, 3) != 0);
            nxt;
        end

        va = '0; vb = '0; rda = 1'b0; rdb = 1'b0;
        repeat (40) nxt;
        chk("a.writes_outstanding", sqa.size(), 0);
        chk("b.writes_outstanding", sqb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
